wb_multiplexer: RTL and testbench
=================================

WB_MULTIPLEXER -- requirements
Module: wb_multiplexer

Interface
REQ-001 The block SHALL have these parameters: Count, default 3, number of slave ports.
REQ-002 The block SHALL have parameter MaskWidth, default 4, number of upper address bits used for slave decode.
REQ-003 The block SHALL have parameters DataWidth and AddrWidth, both default 32.
REQ-004 The block SHALL derive SelWidth = DataWidth/8 as a local parameter.
REQ-005 The block SHALL have these ports, clock and reset first, each as name, direction, width, meaning:
- clk  in  1  single clock; all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m_data_m, m_addr, m_sel  in  DataWidth, AddrWidth, SelWidth  master write data, address, byte select.
- m_cyc, m_stb, m_we  in  1 each  master cycle, strobe, write enable.
- m_data_s  out  DataWidth  read data returned to the master.
- m_ack, m_stall, m_err  out  1 each  response signals to the master.
- s_data_s  in  Count*DataWidth  slave read data; slave i occupies [i*DataWidth +: DataWidth].
- s_ack, s_stall, s_err  in  Count  per-slave responses; bit i belongs to slave i.
- s_data_m, s_addr, s_sel  out  Count*DataWidth, Count*AddrWidth, Count*SelWidth  per-slave copies of the master fields.
- s_cyc, s_stb, s_we  out  Count  per-slave control signals.
REQ-006 The bus protocol SHALL be Wishbone B4 pipelined on both sides.

Function
REQ-007 The decoded index SHALL be m_addr[AddrWidth-1 -: MaskWidth]; index i < Count selects slave i (for example, 0x1000_0000 selects slave 1).
REQ-008 m_data_m, m_addr (unmodified), m_sel and m_we SHALL be broadcast to every slave slice.
REQ-009 s_stb[i] SHALL equal m_cyc & m_stb & (decoded index == i) & ~local_stall; all other bits SHALL be 0.
REQ-010 s_cyc[i] SHALL be 1 while m_cyc=1 and slave i is the strobed or active slave; all other bits SHALL be 0.
REQ-011 The active slave index SHALL be latched on every accepted strobe (m_stb & ~m_stall), and an outstanding counter SHALL be kept:
- +1 per accepted strobe.
- -1 per ack or err from the active slave.
- Accept and response in the same cycle leave the counter unchanged.
REQ-012 The outstanding counter SHALL be 4 bits wide. When it reaches 15, m_stall SHALL be forced to 1.
REQ-013 local_stall SHALL be 1 when the counter is nonzero and the decoded index differs from the active index. This prevents slave switching with transactions in flight.
REQ-014 m_stall SHALL be:
- local_stall, OR
- s_stall of the decoded slave, for a mapped address.
For an unmapped address, m_stall SHALL be local_stall only.
REQ-015 m_ack, m_err and m_data_s SHALL be taken from the active slave while the counter is nonzero or a response arrives. Otherwise m_ack=0, m_err=0 and m_data_s=0.
REQ-016 An accepted strobe to an unmapped index (>= Count) SHALL:
- assert no s_stb or s_cyc;
- pulse m_err for exactly one cycle on the next clock;
- leave m_ack at 0.
REQ-017 Deasserting m_cyc SHALL abort the transfer:
- the counter clears on the next edge;
- all s_cyc go 0 combinationally;
- any late slave responses are ignored.
REQ-018 The responding slave SHALL add no latency: m_ack and m_err are combinational from the active slave, in the same cycle as s_ack and s_err.

Reset
REQ-019 While reset_n=0, the following SHALL clear asynchronously: counter=0, active index=0, pending unmapped error=0.
REQ-020 While reset_n=0, the following outputs SHALL be 0: all s_cyc, all s_stb, m_ack, m_err, m_data_s.
REQ-021 Reset asserted mid-transaction SHALL discard the in-flight transfer; after release, the first new strobe is decoded afresh.

Structure
REQ-022 A shared package wb_pkg SHALL hold the default widths (DataWidth=32, AddrWidth=32) and SelWidth derivation.
REQ-023 Address decode (index extraction plus mapped flag) SHALL be a sub-module wb_addr_decoder. All other logic SHALL be in wb_multiplexer.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Read 0x0000_0004, slave 0 acks with data 0x0000_000A one cycle later -> s_stb=3'b001 for one cycle, m_ack=1, m_data_s=0x0000_000A.
- Write 0x1000_0000, data 0x5, sel 0x1 -> s_stb=3'b010, s_we[1]=1, slave 1 sees data 0x5; m_ack follows s_ack[1].
- Strobe 0x3000_0000 -> no s_stb or s_cyc, m_err=1 exactly one cycle later, m_ack=0.
- Slave 1 holds s_stall=1 for 3 cycles -> m_stall=1 for those 3 cycles; s_stb[1] is held, and the transfer is accepted on the first cycle with s_stall=0.
- Strobe slave 0 then immediately slave 1 before the ack -> m_stall=1 until ack from slave 0, then slave 1 is strobed.
- Assert reset_n=0 with one read outstanding -> s_cyc=0 and m_ack=0 immediately; a late s_ack[0] produces no m_ack.

Source files
------------

// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared Wishbone bus defaults for the multiplexer slice.
//   DATA_WIDTH / ADDR_WIDTH : default bus widths
//   CNT_WIDTH               : width of the outstanding-transaction counter
//   sel_width()             : byte-select width derived from the data width
// ----------------------------------------------------------------------------
package wb_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int CNT_WIDTH  = 4;

    function automatic int sel_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// ----------------------------------------------------------------------------
// wb_addr_decoder
// Extracts the slave index from the top address bits and flags whether that
// index maps onto an existing slave port.
//   i_addr   : master address
//   o_idx    : i_addr[AddrWidth-1 -: MaskWidth]
//   o_mapped : 1 when o_idx < Count
// ----------------------------------------------------------------------------
module wb_addr_decoder
    import wb_pkg::*;
#(
    parameter int Count     = 3,
    parameter int MaskWidth = 4,
    parameter int AddrWidth = ADDR_WIDTH
) (
    input  logic [AddrWidth-1:0] i_addr,
    output logic [MaskWidth-1:0] o_idx,
    output logic                 o_mapped
);

    // Lower address bits are not part of the decode; they are broadcast
    // unmodified by the top level.
    logic w_unused_lo;

    assign o_idx       = i_addr[AddrWidth-1 -: MaskWidth];
    assign o_mapped    = (int'(o_idx) < Count);
    assign w_unused_lo = ^i_addr[AddrWidth-MaskWidth-1:0];

endmodule

// File: rtl/wb_multiplexer.sv
// ----------------------------------------------------------------------------
// wb_multiplexer
// One Wishbone B4 pipelined master fanned out to Count pipelined slaves.
// The slave is chosen by the top MaskWidth address bits. Transactions to a
// slave may be pipelined; switching to another slave waits until every
// outstanding response has returned, so responses stay in order.
//
// Ports
//   clk, reset_n                 : clock, async active-low reset
//   m_data_m/m_addr/m_sel        : master write data, address, byte select
//   m_cyc/m_stb/m_we             : master cycle, strobe, write enable
//   m_data_s/m_ack/m_stall/m_err : response path back to the master
//   s_data_s/s_ack/s_stall/s_err : packed per-slave responses (slave i at
//                                  slice i)
//   s_data_m/s_addr/s_sel/s_we   : master fields broadcast to every slave
//   s_cyc/s_stb                  : per-slave cycle / strobe
// ----------------------------------------------------------------------------
module wb_multiplexer
    import wb_pkg::*;
#(
    parameter  int Count     = 3,
    parameter  int MaskWidth = 4,
    parameter  int DataWidth = DATA_WIDTH,
    parameter  int AddrWidth = ADDR_WIDTH,
    localparam int SelWidth  = sel_width(DataWidth)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    // master side
    input  logic [DataWidth-1:0]       m_data_m,
    input  logic [AddrWidth-1:0]       m_addr,
    input  logic [SelWidth-1:0]        m_sel,
    input  logic                       m_cyc,
    input  logic                       m_stb,
    input  logic                       m_we,
    output logic [DataWidth-1:0]       m_data_s,
    output logic                       m_ack,
    output logic                       m_stall,
    output logic                       m_err,
    // slave side
    input  logic [Count*DataWidth-1:0] s_data_s,
    input  logic [Count-1:0]           s_ack,
    input  logic [Count-1:0]           s_stall,
    input  logic [Count-1:0]           s_err,
    output logic [Count*DataWidth-1:0] s_data_m,
    output logic [Count*AddrWidth-1:0] s_addr,
    output logic [Count*SelWidth-1:0]  s_sel,
    output logic [Count-1:0]           s_cyc,
    output logic [Count-1:0]           s_stb,
    output logic [Count-1:0]           s_we
);

    logic [MaskWidth-1:0] w_idx;
    logic                 w_mapped;

    logic [MaskWidth-1:0] r_active;     // slave owning the in-flight transfers
    logic [CNT_WIDTH-1:0] r_cnt;        // transfers accepted but not answered
    logic                 r_unm_err;    // error owed for an unmapped strobe

    logic                 w_busy;
    logic                 w_full;
    logic                 w_local_stall;
    logic                 w_dec_stall;
    logic                 w_accept;
    logic                 w_rsp_en;
    logic                 w_rsp;
    logic                 w_act_ack;
    logic                 w_act_err;
    logic [DataWidth-1:0] w_act_data;

    wb_addr_decoder #(
        .Count     (Count),
        .MaskWidth (MaskWidth),
        .AddrWidth (AddrWidth)
    ) u_dec (
        .i_addr   (m_addr),
        .o_idx    (w_idx),
        .o_mapped (w_mapped)
    );

    assign w_busy = (r_cnt != '0);
    assign w_full = (r_cnt == '1);

    // Hold off a strobe to a different slave while responses are pending.
    // A full counter is folded in too, so a slave never sees s_stb for a
    // request the master has been told is stalled.
    assign w_local_stall = (w_busy && (w_idx != r_active)) || w_full;

    // Per-slave selection: stall of the decoded slave, response of the
    // active one. Unmapped indices match no slave and read as zero.
    always_comb begin
        w_dec_stall = 1'b0;
        w_act_ack   = 1'b0;
        w_act_err   = 1'b0;
        w_act_data  = '0;
        for (int i = 0; i < Count; i++) begin
            if (w_idx == MaskWidth'(i)) begin
                w_dec_stall = s_stall[i];
            end
            if (r_active == MaskWidth'(i)) begin
                w_act_ack  = s_ack[i];
                w_act_err  = s_err[i];
                w_act_data = s_data_s[i*DataWidth +: DataWidth];
            end
        end
    end

    assign m_stall  = w_local_stall || (w_mapped && w_dec_stall);
    assign w_accept = m_cyc && m_stb && !m_stall;

    // Responses only pass while the cycle is alive and something is owed;
    // stray acks after an abort or reset are dropped here.
    assign w_rsp_en = m_cyc && w_busy;
    assign m_ack    = w_rsp_en && w_act_ack;
    assign m_err    = (w_rsp_en && w_act_err) || (m_cyc && r_unm_err);
    assign m_data_s = w_rsp_en ? w_act_data : '0;
    assign w_rsp    = m_ack || m_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_active  <= '0;
            r_unm_err <= 1'b0;
        end else if (!m_cyc) begin
            r_cnt     <= '0;
            r_unm_err <= 1'b0;
        end else begin
            // An unmapped strobe counts as outstanding until its own error
            // pulse retires it, which keeps the no-switch rule uniform.
            r_cnt     <= r_cnt + CNT_WIDTH'(w_accept) - CNT_WIDTH'(w_rsp);
            r_unm_err <= w_accept && !w_mapped;
            if (w_accept) begin
                r_active <= w_idx;
            end
        end
    end

    always_comb begin
        s_stb = '0;
        s_cyc = '0;
        for (int i = 0; i < Count; i++) begin
            if (reset_n && m_cyc) begin
                if (m_stb && (w_idx == MaskWidth'(i)) && !w_local_stall) begin
                    s_stb[i] = 1'b1;
                    s_cyc[i] = 1'b1;
                end
                if (w_busy && (r_active == MaskWidth'(i))) begin
                    s_cyc[i] = 1'b1;
                end
            end
        end
    end

    assign s_data_m = {Count{m_data_m}};
    assign s_addr   = {Count{m_addr}};
    assign s_sel    = {Count{m_sel}};
    assign s_we     = {Count{m_we}};

endmodule

// File: tb/tb_wb_multiplexer.sv
module tb_wb_multiplexer;

    localparam int NS = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [DW-1:0]     m_data_m, m_data_s;
    logic [AW-1:0]     m_addr;
    logic [SW-1:0]     m_sel;
    logic              m_cyc, m_stb, m_we, m_ack, m_stall, m_err;
    logic [NS*DW-1:0]  s_data_s, s_data_m;
    logic [NS*AW-1:0]  s_addr;
    logic [NS*SW-1:0]  s_sel;
    logic [NS-1:0]     s_ack, s_stall, s_err, s_cyc, s_stb, s_we;

    // Slave inputs come either from directed pokes or from the slave models.
    logic              manual = 1'b1;
    logic [NS-1:0]     man_ack = '0, man_err = '0, man_stall = '0;
    logic [NS*DW-1:0]  man_data = '0;
    logic [NS-1:0]     emu_ack = '0, emu_err = '0, emu_stall = '0;
    logic [NS*DW-1:0]  emu_data = '0;
    logic              hold_ack = 1'b0;
    logic              stall_en = 1'b1;

    assign s_ack    = manual ? man_ack   : emu_ack;
    assign s_err    = manual ? man_err   : emu_err;
    assign s_stall  = manual ? man_stall : emu_stall;
    assign s_data_s = manual ? man_data  : emu_data;

    always #5 clk = ~clk;

    wb_multiplexer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m_data_m (m_data_m),
        .m_addr   (m_addr),
        .m_sel    (m_sel),
        .m_cyc    (m_cyc),
        .m_stb    (m_stb),
        .m_we     (m_we),
        .m_data_s (m_data_s),
        .m_ack    (m_ack),
        .m_stall  (m_stall),
        .m_err    (m_err),
        .s_data_s (s_data_s),
        .s_ack    (s_ack),
        .s_stall  (s_stall),
        .s_err    (s_err),
        .s_data_m (s_data_m),
        .s_addr   (s_addr),
        .s_sel    (s_sel),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Reference model: every slave is a 256-word memory; slave 2 rejects
    // words whose low two index bits are 3; indices >= NS give an error.
    // Responses return in the order requests were accepted.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [NS][256];

    task automatic model_push(input logic [AW-1:0] a, input logic we,
                              input logic [DW-1:0] d, input logic [SW-1:0] sel);
        int   slv;
        int   w;
        rsp_t r;
        slv = int'(a[31:28]);
        w   = int'(a[9:2]);
        r.err  = 1'b0;
        r.data = '0;
        if (slv >= NS) begin
            r.err = 1'b1;
        end else if (slv == 2 && a[3:2] == 2'b11) begin
            r.err = 1'b1;
        end else if (we) begin
            for (int b = 0; b < SW; b++)
                if (sel[b]) ref_mem[slv][w][8*b +: 8] = d[8*b +: 8];
        end else begin
            r.data = ref_mem[slv][w];
        end
        exp_q.push_back(r);
    endtask

    // ------------------------------------------------------------------
    // Slave models: accept on stb & ~stall, answer in order after a random
    // delay, stall randomly.
    // ------------------------------------------------------------------
    rsp_t          sq [NS][$];
    logic [DW-1:0] smem [NS][256];

    always @(negedge clk) begin
        logic [AW-1:0] a;
        int            w;
        rsp_t          r;
        if (!manual) begin
            for (int i = 0; i < NS; i++) begin
                if ((emu_ack[i] || emu_err[i]) && sq[i].size() > 0)
                    void'(sq[i].pop_front());
                if (s_cyc[i] && s_stb[i] && !s_stall[i]) begin
                    a = s_addr[i*AW +: AW];
                    w = int'(a[9:2]);
                    r.err  = 1'b0;
                    r.data = '0;
                    if (i == 2 && a[3:2] == 2'b11) begin
                        r.err = 1'b1;
                    end else if (s_we[i]) begin
                        for (int b = 0; b < SW; b++)
                            if (s_sel[i*SW + b])
                                smem[i][w][8*b +: 8] = s_data_m[i*DW + 8*b +: 8];
                    end else begin
                        r.data = smem[i][w];
                    end
                    sq[i].push_back(r);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NS; i++) begin
            emu_stall[i]          = stall_en && ($urandom_range(0, 3) == 0);
            emu_ack[i]            = 1'b0;
            emu_err[i]            = 1'b0;
            emu_data[i*DW +: DW]  = '0;
            if (!manual && !hold_ack && sq[i].size() > 0 && $urandom_range(0, 1) == 1) begin
                emu_ack[i]           = !sq[i][0].err;
                emu_err[i]           = sq[i][0].err;
                emu_data[i*DW +: DW] = sq[i][0].data;
            end
        end
    end

    // Monitor: every response seen by the master is matched against the
    // oldest expected response.
    always @(negedge clk) begin
        rsp_t e;
        if (!manual && reset_n && (m_ack || m_err)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rsp: got ack=%0b err=%0b, want none", m_ack, m_err);
            end else begin
                e = exp_q.pop_front();
                check("rsp_ack", m_ack, !e.err);
                check("rsp_err", m_err, e.err);
                if (!e.err) check("rsp_data", m_data_s, e.data);
            end
        end
    end

    // Drive one request and hold it until accepted.
    task automatic issue(input logic [AW-1:0] a, input logic we,
                         input logic [DW-1:0] d, input logic [SW-1:0] sel);
        int            n;
        int            slv;
        logic [NS-1:0] oh;
        n   = 0;
        slv = int'(a[31:28]);
        oh  = (slv < NS) ? NS'(1 << slv) : '0;
        m_cyc = 1'b1; m_stb = 1'b1; m_addr = a; m_we = we; m_data_m = d; m_sel = sel;
        forever begin
            smp();
            if (!m_stall) break;
            n++;
            if (n > 100) begin
                n_vec++;
                n_bad++;
                $display("FAIL accept_timeout: addr 0x%08h still stalled after %0d cycles", a, n);
                break;
            end
            tick();
        end
        if (n <= 100) begin
            check("stb_onehot", s_stb, oh);
            model_push(a, we, d, sel);
        end
        tick();
        m_stb = 1'b0;
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic we,
                         input logic [DW-1:0] d, input logic [SW-1:0] sel);
        m_cyc = 1'b1; m_stb = 1'b1; m_addr = a; m_we = we; m_data_m = d; m_sel = sel;
    endtask

    initial begin
        int            pick;
        logic [3:0]    idx;
        logic [AW-1:0] a;
        int            n;

        for (int i = 0; i < NS; i++)
            for (int j = 0; j < 256; j++) begin
                ref_mem[i][j] = '0;
                smem[i][j]    = '0;
            end
        m_cyc = 0; m_stb = 0; m_we = 0; m_addr = '0; m_data_m = '0; m_sel = '0;

        // Reset holds every slave and master response low.
        #2;
        reset_n = 1'b0;
        drive(32'h0000_0000, 1'b0, '0, '0);
        man_ack = '1; man_err = '1; man_data = '1;
        #1;
        check("rst_s_cyc", s_cyc, 3'b000);
        check("rst_s_stb", s_stb, 3'b000);
        check("rst_m_ack", m_ack, 1'b0);
        check("rst_m_err", m_err, 1'b0);
        check("rst_m_data", m_data_s, 32'h0);
        m_cyc = 0; m_stb = 0; man_ack = '0; man_err = '0; man_data = '0;
        tick(); tick();
        reset_n = 1'b1;

        // Read slave 0, ack one cycle later.
        tick();
        drive(32'h0000_0004, 1'b0, '0, 4'hF);
        smp(); check("rd_stb", s_stb, 3'b001); check("rd_stall", m_stall, 1'b0);
        tick(); m_stb = 0; man_ack = 3'b001; man_data[31:0] = 32'h0000_000A;
        smp(); check("rd_ack", m_ack, 1'b1); check("rd_data", m_data_s, 32'hA);
        check("rd_stb_drop", s_stb, 3'b000); check("rd_cyc", s_cyc, 3'b001);
        tick(); man_ack = '0;
        smp(); check("rd_ack_end", m_ack, 1'b0); check("rd_cyc_end", s_cyc, 3'b000);

        // Write slave 1.
        tick();
        drive(32'h1000_0000, 1'b1, 32'h5, 4'h1);
        smp(); check("wr_stb", s_stb, 3'b010); check("wr_we", s_we[1], 1'b1);
        check("wr_data", s_data_m[63:32], 32'h5); check("wr_sel", s_sel[7:4], 4'h1);
        check("wr_addr", s_addr[63:32], 32'h1000_0000);
        tick(); m_stb = 0; man_ack = 3'b010;
        smp(); check("wr_ack", m_ack, 1'b1);
        tick(); man_ack = '0;

        // Unmapped strobe.
        drive(32'h3000_0000, 1'b0, '0, 4'hF);
        smp(); check("unm_stb", s_stb, 3'b000); check("unm_cyc", s_cyc, 3'b000);
        check("unm_err_early", m_err, 1'b0); check("unm_stall", m_stall, 1'b0);
        tick(); m_stb = 0;
        smp(); check("unm_err", m_err, 1'b1); check("unm_ack", m_ack, 1'b0);
        tick();
        smp(); check("unm_err_once", m_err, 1'b0);

        // Slave 1 stalls three cycles.
        tick(); man_stall = 3'b010;
        drive(32'h1000_0008, 1'b0, '0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            smp(); check("sst_stall", m_stall, 1'b1); check("sst_stb", s_stb, 3'b010);
            tick();
        end
        man_stall = '0;
        smp(); check("sst_accept", m_stall, 1'b0); check("sst_stb_acc", s_stb, 3'b010);
        tick(); m_stb = 0; man_ack = 3'b010; man_data[63:32] = 32'h77;
        smp(); check("sst_ack", m_ack, 1'b1); check("sst_data", m_data_s, 32'h77);
        tick(); man_ack = '0;

        // Switch slaves with a response pending.
        drive(32'h0000_0010, 1'b0, '0, 4'hF);
        smp(); check("sw_acc0", m_stall, 1'b0);
        tick(); m_addr = 32'h1000_0010;
        smp(); check("sw_stall", m_stall, 1'b1); check("sw_no_stb", s_stb, 3'b000);
        check("sw_cyc", s_cyc, 3'b001);
        tick(); man_ack = 3'b001;
        smp(); check("sw_ack0", m_ack, 1'b1); check("sw_stall_ack", m_stall, 1'b1);
        tick(); man_ack = '0;
        smp(); check("sw_go", m_stall, 1'b0); check("sw_stb1", s_stb, 3'b010);
        tick(); m_stb = 0; man_ack = 3'b010;
        smp(); check("sw_ack1", m_ack, 1'b1);
        tick(); man_ack = '0;

        // Abort by dropping m_cyc.
        drive(32'h0000_0020, 1'b0, '0, 4'hF);
        smp();
        tick(); m_cyc = 0; m_stb = 0;
        smp(); check("abt_cyc", s_cyc, 3'b000);
        tick(); m_cyc = 1; man_ack = 3'b001;
        smp(); check("abt_late_ack", m_ack, 1'b0);
        tick(); man_ack = '0;

        // Reset with a read outstanding.
        drive(32'h0000_0030, 1'b0, '0, 4'hF);
        smp();
        tick(); m_stb = 0;
        smp(); check("rmid_cyc_pre", s_cyc, 3'b001);
        tick(); reset_n = 1'b0; man_ack = 3'b001;
        #1; check("rmid_cyc", s_cyc, 3'b000); check("rmid_ack", m_ack, 1'b0);
        tick(); reset_n = 1'b1;
        smp(); check("rmid_late_ack", m_ack, 1'b0);
        tick(); man_ack = '0; m_cyc = 0;

        // Randomised traffic through the slave models.
        tick();
        manual = 1'b0;
        tick();

        // Fill the outstanding counter to 15 on slave 0.
        stall_en = 1'b0; hold_ack = 1'b1;
        for (int k = 0; k < 15; k++)
            issue({4'h0, 18'h0, 8'(k + 64), 2'b00}, 1'b0, '0, 4'hF);
        drive(32'h0000_0200, 1'b0, '0, 4'hF);
        smp(); check("full_stall", m_stall, 1'b1); check("full_no_stb", s_stb, 3'b000);
        tick(); m_stb = 0; hold_ack = 1'b0; stall_en = 1'b1;

        for (int k = 0; k < 300; k++) begin
            pick = $urandom_range(0, 7);
            if (pick < 6) idx = 4'(pick % 3);
            else          idx = 4'(3 + $urandom_range(0, 12));
            a = {idx, 18'h0, 4'h0, 4'($urandom_range(0, 15)), 2'b00};
            issue(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)));
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) tick();
        end

        n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            tick();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        m_cyc = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
